// File: rtl/seq_mult_ctrl_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier controller.
// State encoding is fixed so the unused code 2'b11 is known to fall back to IDLE.
package seq_mult_ctrl_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Iteration counter width for a given operand width; must also hold the value WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl_ripple_add.sv
// WIDTH-bit ripple-carry adder: half-adder cell at bit 0, full-adder cells above.
// Each stage keeps its own carry so the chain has no self-referencing vector.
module ripple_add #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic co;
        if (i == 0) begin : g_ha
            assign sum[i] = a[i] ^ b[i];
            assign co     = a[i] & b[i];
        end else begin : g_fa
            assign sum[i] = a[i] ^ b[i] ^ g_bit[i-1].co;
            assign co     = (a[i] & b[i]) | (g_bit[i-1].co & (a[i] ^ b[i]));
        end
    end

    assign cout = g_bit[WIDTH-1].co;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add unsigned multiplier: one shared WIDTH-bit adder, one iteration per clock,
// start/busy/done handshake, exact 2*WIDTH-bit product held until the next completion.
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_hi_nxt;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   acc_lo_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mcand_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [PW-1:0]      product_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               carry;
    logic [PW-1:0]      shifted;

    // Only the adder's b operand is muxed; a zero addend passes acc_hi through with no carry.
    assign add_b = acc_lo[0] ? mcand : '0;

    ripple_add #(
        .WIDTH(WIDTH)
    ) u_add (
        .a   (acc_hi),
        .b   (add_b),
        .sum (add_sum),
        .cout(add_cout)
    );

    assign carry   = add_cout & acc_lo[0];
    // {carry,sum,acc_lo} >> 1, with the discarded LSB simply not wired.
    assign shifted = {carry, add_sum, acc_lo[WIDTH-1:1]};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc_hi  <= '0;
            acc_lo  <= '0;
            mcand   <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc_hi  <= acc_hi_nxt;
            acc_lo  <= acc_lo_nxt;
            mcand   <= mcand_nxt;
            cnt     <= cnt_nxt;
            product <= product_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state, iteration datapath and registered-output decode.
    always_comb begin
        state_nxt   = state;
        acc_hi_nxt  = acc_hi;
        acc_lo_nxt  = acc_lo;
        mcand_nxt   = mcand;
        cnt_nxt     = cnt;
        product_nxt = product;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    mcand_nxt  = multiplicand;
                    acc_lo_nxt = multiplier;
                    acc_hi_nxt = '0;
                    cnt_nxt    = '0;
                    state_nxt  = ST_RUN;
                    busy_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                acc_hi_nxt = shifted[PW-1:WIDTH];
                acc_lo_nxt = shifted[WIDTH-1:0];
                cnt_nxt    = cnt + CNT_W'(1);
                busy_nxt   = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt   = ST_DONE;
                    product_nxt = shifted;
                    done_nxt    = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed self-checking bench for seq_mult_ctrl at WIDTH=8 with hand-computed products.
module tb_seq_mult_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LAT   = WIDTH;  // edges after the start edge until done is visible
    localparam int unsigned LIMIT = 40;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_checks;
    int n_fail;

    seq_mult_ctrl #(
        .WIDTH(WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Wait for done, continuing a latency count already started at the start edge.
    task automatic wait_done(input int lat_in, output int lat);
        lat = lat_in;
        while (!done && lat < int'(LIMIT)) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full operation from a point just after a clock edge; start is dropped after acceptance.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [15:0] exp);
        int lat;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 8'hA5;
        multiplier   = 8'h5A;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_done_early"}, 32'(done), 32'd0);
        wait_done(0, lat);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_product"}, 32'(product), 32'(exp));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_product_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int lat;
        int gap;
        int changes;
        int pulses;

        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("m13x11", 8'd13, 8'd11, 16'h008F);
        run_op("m255x255", 8'd255, 8'd255, 16'hFE01);
        run_op("m0x200", 8'd0, 8'd200, 16'd0);
        run_op("m200x0", 8'd200, 8'd0, 16'd0);

        // Second start request during RUN must be ignored.
        multiplicand = 8'd7;
        multiplier   = 8'd6;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_done_early", 32'(done), 32'd0);
        wait_done(4, lat);
        check("ign_latency", 32'(lat), 32'(LAT));
        check("ign_product", 32'(product), 32'd42);
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("ign_extra_done", 32'(pulses), 32'd0);
        check("ign_busy_idle", 32'(busy), 32'd0);
        check("ign_product_hold", 32'(product), 32'd42);

        // Reset partway through an operation aborts it and clears product.
        multiplicand = 8'd100;
        multiplier   = 8'd3;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle_product", 32'(product), 32'd0);
        run_op("m5x5", 8'd5, 8'd5, 16'd25);

        // start held high: back-to-back operations, one result per WIDTH+2 cycles.
        multiplicand = 8'd12;
        multiplier   = 8'd12;
        start        = 1'b1;
        @(posedge clk);
        #1;
        multiplicand = 8'd3;
        multiplier   = 8'd4;
        wait_done(0, lat);
        check("b2b_latency1", 32'(lat), 32'(LAT));
        check("b2b_product1", 32'(product), 32'd144);
        gap     = 0;
        changes = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
            if (!done && product != 16'd144) changes++;
        end while (!done && gap < int'(LIMIT));
        start = 1'b0;
        check("b2b_gap", 32'(gap), 32'(WIDTH + 2));
        check("b2b_hold", 32'(changes), 32'd0);
        check("b2b_product2", 32'(product), 32'd12);
        @(posedge clk);
        #1;
        check("b2b_done_pulse", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_busy_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Sequential shift-and-add unsigned multiplier controller.
- Sequences one shared WIDTH-bit ripple adder over WIDTH iterations, one per clock, to form a 2*WIDTH-bit product.
- Sits in the Multiplier datapath as the area-lean alternative to the combinational array multiplier.
- Host handshake is start/busy/done.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- multiplicand  input  WIDTH  operand A, unsigned; sampled on the accepted start edge
- multiplier  input  WIDTH  operand B, unsigned; sampled on the accepted start edge
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- product  output  2*WIDTH  last completed result; held until next completion

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous, active-low, single clock domain. While rst_n is low:
  - state=IDLE; busy=0, done=0, product=0;
  - internal acc_hi=0, acc_lo=0, mcand=0, carry=0, cnt=0.
  - Deassertion takes effect at the next rising edge.
- Reset mid-operation aborts immediately. No partial result reaches product; product returns to 0.
- FSM has 3 states:
  - IDLE: if start=1 at an edge: mcand<=multiplicand, acc_lo<=multiplier, acc_hi<=0, cnt<=0, go to RUN. Otherwise stay in IDLE.
  - RUN: each edge performs one iteration. After the edge where cnt reaches WIDTH-1, go to DONE and load product<=final {acc_hi,acc_lo}.
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Iteration arithmetic in RUN:
  - If acc_lo[0]=1: {carry,sum} = acc_hi + mcand through the shared adder. Otherwise sum=acc_hi, carry=0.
  - Then {acc_hi,acc_lo} <= {carry,sum,acc_lo} >> 1, a right shift of the (2*WIDTH+1)-bit concatenation.
  - cnt increments by 1.
- Width rule: adder result is WIDTH+1 bits; the carry is never dropped. The product is exact for all unsigned inputs (max (2^W-1)^2).
- Latency: start accepted at edge E0. RUN covers edges E1..E_WIDTH. done is high in the cycle after E_WIDTH, i.e. sampled high at edge E_(WIDTH+1). Total WIDTH+1 cycles from the start edge to done. Fixed latency; there is no early termination on a zero multiplier.
- busy rises in the cycle after E0 and falls in the cycle after DONE.
- start while busy (RUN or DONE) is ignored: no re-latch and no queueing.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE, so back-to-back throughput is one result per WIDTH+2 cycles.
- Operand inputs may change freely after the accepted start edge; only the latched copies are used.
- product changes only on DONE entry or reset. It is stable in IDLE and RUN.

Decomposition:
- Shared package/include holds the state encoding localparams: ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10. 2'b11 is illegal and recovers to IDLE.
- One sub-module, ripple_add: WIDTH-bit adder with inputs a, b and outputs sum[WIDTH-1:0] and cout.
  - Built as a generate chain whose LSB is a half-adder cell and whose upper bits are full-adder cells.
  - Instantiated once; the controller only muxes its b input (mcand or 0).

Test Plan:
- WIDTH=8, reset then start with 13 x 11 -> busy=1 from the next cycle; done pulses exactly 9 cycles after the start edge; product=143 (16'h008F); busy=0 the cycle after.
- 255 x 255 -> product=65025 (16'hFE01); proves the carry is kept every iteration.
- 0 x 200 and 200 x 0 -> product=0; latency still 9 cycles; done still pulses once.
- Start 7 x 6, then pulse start with 9 x 9 during RUN -> product=42 and a single done pulse; the second request is ignored and busy is unchanged.
- Start 100 x 3, assert rst_n=0 at iteration 4 -> outputs 0 immediately; after release, start 5 x 5 -> product=25 with normal latency.
- start held high across two operations (12 x 12 then 3 x 4) -> products 144 then 12; the second done arrives 10 cycles after the first; product stays 144 between them.
